// File: rtl/aes_decrypt_round_ctrl.sv
// rtl/aes_decrypt_round_ctrl.sv - AES-128 inverse-cipher round sequencer (optional abort input: AES_DEC_ABORT_EN)
module aes_decrypt_round_ctrl #(
  parameter int NR        = 10,
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef AES_DEC_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         round_key,
  output logic [1:0]           dp_mode,
  output logic [127:0]         dp_state,
  input  logic [127:0]         dp_result,
  output logic                 busy
);

  localparam int CW = $clog2(NR + 1);

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_INIT  = 2'b01;
  localparam logic [1:0] MODE_MID   = 2'b10;
  localparam logic [1:0] MODE_FINAL = 2'b11;

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [127:0]  sreg;
  logic          abort_req;

  // Abort request exists only in the abort-capable build.
`ifdef AES_DEC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // round_key feeds the external datapath directly; the sequencer never looks at it.
  logic unused_round_key;
  assign unused_round_key = ^round_key;

  // in_ready is gated by reset so no block is accepted while reset is held.
  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state == INIT) || (state == ROUND) || (state == FINAL);
  assign out_data = sreg;
  assign dp_state = sreg;

  // Sequencer: key_idx/dp_mode are registered one state ahead so they line up with the state they serve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      out_valid <= 1'b0;
      key_idx   <= '0;
      dp_mode   <= MODE_IDLE;
    end else if (abort_req && busy) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      out_valid <= 1'b0;
      key_idx   <= '0;
      dp_mode   <= MODE_IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg    <= in_data;
            state   <= INIT;
            key_idx <= KEY_IDX_W'(NR);
            dp_mode <= MODE_INIT;
          end
        end
        INIT: begin
          sreg    <= dp_result;
          cnt     <= CW'(NR - 1);
          state   <= ROUND;
          key_idx <= KEY_IDX_W'(NR - 1);
          dp_mode <= MODE_MID;
        end
        ROUND: begin
          sreg <= dp_result;
          if (cnt == CW'(1)) begin
            state   <= FINAL;
            key_idx <= '0;
            dp_mode <= MODE_FINAL;
          end else begin
            cnt     <= cnt - CW'(1);
            key_idx <= KEY_IDX_W'(cnt - CW'(1));
          end
        end
        FINAL: begin
          sreg      <= dp_result;
          state     <= DONE;
          key_idx   <= '0;
          dp_mode   <= MODE_IDLE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_round_ctrl.sv
// tb/tb_aes_decrypt_round_ctrl.sv - self-checking bench for aes_decrypt_round_ctrl
module tb_aes_decrypt_round_ctrl;

  localparam int NR = 10;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  out_data;
  logic [KW-1:0] key_idx;
  logic [127:0]  round_key;
  logic [1:0]    dp_mode;
  logic [127:0]  dp_state;
  logic [127:0]  dp_result;
  logic          busy;
`ifdef AES_DEC_ABORT_EN
  logic          abort = 1'b0;
`endif

  aes_decrypt_round_ctrl #(.NR(NR), .KEY_IDX_W(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_DEC_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .key_idx   (key_idx),
    .round_key (round_key),
    .dp_mode   (dp_mode),
    .dp_state  (dp_state),
    .dp_result (dp_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] ks    [11];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] isr(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] isb(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = isbox[s[127 - 8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] imc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 8*(4*c)   -: 8];
      a1 = s[127 - 8*(4*c+1) -: 8];
      a2 = s[127 - 8*(4*c+2) -: 8];
      a3 = s[127 - 8*(4*c+3) -: 8];
      o[127 - 8*(4*c)   -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
      o[127 - 8*(4*c+1) -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
      o[127 - 8*(4*c+2) -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
      o[127 - 8*(4*c+3) -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
    end
    return o;
  endfunction

  // External round datapath, grouped the way the controller's dp_mode describes it.
  function automatic logic [127:0] dp_model(input logic [1:0] m, input logic [127:0] s, input logic [127:0] k);
    case (m)
      2'b01:   return isb(isr(s ^ k));
      2'b10:   return isb(isr(imc(s ^ k)));
      2'b11:   return s ^ k;
      default: return s;
    endcase
  endfunction

  // Textbook inverse cipher ordering, used for expected plaintexts.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ ks[10];
    for (int r = 9; r >= 1; r--) begin
      s = isb(isr(s));
      s = s ^ ks[r];
      s = imc(s);
    end
    s = isb(isr(s));
    return s ^ ks[0];
  endfunction

  assign round_key = (int'(key_idx) <= NR) ? ks[key_idx] : '0;
  assign dp_result = dp_model(dp_mode, dp_state, round_key);

  // ---------------- scoreboard / monitor ----------------
  logic [127:0] exp_q [$];
  int  acc_edge = 0;
  int  last_out_edge = -100;
  int  n_acc = 0;
  bit  seq_on = 1'b0;
  logic ov_d = 1'b0;
  int  mj;
  logic [3:0] ek;
  logic [1:0] em;

  always @(negedge clk) begin
    if (rst_n) begin
      if (seq_on) begin
        mj = cyc - acc_edge;
        if (mj == 0)      begin ek = 4'd10;          em = 2'b01; end
        else if (mj <= 9) begin ek = 4'(10 - mj);    em = 2'b10; end
        else if (mj == 10) begin ek = 4'd0;          em = 2'b11; end
        else              begin ek = 4'd0;           em = 2'b00; end
        chk($sformatf("key_idx_step%0d", mj), 128'(key_idx), 128'(ek));
        chk($sformatf("dp_mode_step%0d", mj), 128'(dp_mode), 128'(em));
      end
      if (out_valid && !ov_d) chk("latency", 128'(cyc - acc_edge), 128'(11));
      ov_d = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 128'(1), 128'(0));
        else chk("plaintext", out_data, exp_q.pop_front());
        last_out_edge = cyc + 1;
        seq_on = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_decrypt(in_data));
        acc_edge = cyc + 1;
        n_acc++;
        seq_on = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_out_valid(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("timeout_out_valid", 128'(0), 128'(1));
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, input int stall);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = ct;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(20);
    for (int s = 0; s < stall; s++) begin
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_out_data", out_data, pt);
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_xfer_in_ready", 128'(in_ready), 128'(1));
    chk("post_xfer_out_valid", 128'(out_valid), 128'(0));
  endtask

  // Runs a block into the middle rounds and stops at the cycle where key_idx==5 (counter 5).
  task automatic start_and_reach_round5();
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(key_idx == 4'd5 && dp_mode == 2'b10) && n < 15) begin
      @(negedge clk);
      n++;
    end
    chk("reach_round5", 128'(key_idx), 128'(5));
    seq_on = 1'b0;
  endtask

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           stall;
  } vec_t;

  vec_t vt [4];
  logic [127:0] ct_a, ct_b;
  bit saw;

  initial begin
    build_tables();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);

    vt[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 2};
    vt[1].ct = {$urandom, $urandom, $urandom, $urandom};
    vt[1].pt = ref_decrypt(vt[1].ct);
    vt[1].stall = 0;
    vt[2].ct = {$urandom, $urandom, $urandom, $urandom};
    vt[2].pt = ref_decrypt(vt[2].ct);
    vt[2].stall = 20;
    vt[3].ct = '0;
    vt[3].pt = ref_decrypt(vt[3].ct);
    vt[3].stall = 1;

    chk("fips_c1_reference", ref_decrypt(vt[0].ct), vt[0].pt);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_key_idx", 128'(key_idx), 128'(0));
    chk("rst_dp_mode", 128'(dp_mode), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'(1));

    // table-driven blocks, including a 20-cycle output stall
    for (int i = 0; i < 4; i++) send_block(vt[i].ct, vt[i].pt, vt[i].stall);

    // back-to-back with in_valid and out_ready held high
    ct_a = {$urandom, $urandom, $urandom, $urandom};
    ct_b = {$urandom, $urandom, $urandom, $urandom};
    begin
      int base, n;
      base = n_acc;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = ct_a;
      @(posedge clk); #1;
      in_data = ct_b;
      n = 0;
      while (n_acc < base + 2 && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_two_accepts", 128'(n_acc - base), 128'(2));
      chk("b2b_accept_after_output", 128'(acc_edge), 128'(last_out_edge + 1));
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
    end

    // reset mid-run at counter 5
    start_and_reach_round5();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready_low", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    ov_d = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_state_reg", out_data, 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("midrst_no_output", 128'(saw), 128'(0));

`ifdef AES_DEC_ABORT_EN
    // abort in ROUND, then a normal block
    start_and_reach_round5();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_state_reg", out_data, 128'(0));
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("abort_no_output", 128'(saw), 128'(0));
    send_block(vt[0].ct, vt[0].pt, 1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
